// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter onto a single
// native memory interface. A 3-state FSM grants one requester at a time.
// When both ports request together, the port served last loses.
// Optional feature macro: MEM_ARB_TIMEOUT_EN. When it is defined, a granted
// transaction is aborted after TIMEOUT_CYCLES busy cycles without mem_ready.
// The aborted requester receives 32'hDEADBEEF and a one-cycle timeout pulse.
//
// Handshake: a requester holds x_valid with stable address/data until the
// arbiter raises x_ready for one cycle. x_rdata is meaningful only in that
// cycle and is 0 otherwise. On the memory side, mem_valid is held for the
// whole busy phase, and the transfer completes in the first cycle in which
// mem_ready is high. mem_ready is ignored while the arbiter is idle.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        timeout,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  // 1 = the data port was served last, 0 = the fetch port was served last.
  logic   last_d_q, last_d_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  // The counter holds (busy cycles elapsed - 1), so the abort happens in busy cycle TIMEOUT_CYCLES.
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign dbg_state = state_q;

  // Next-state, last-grant, and all combinational outputs.
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    i_ready   = 1'b0;
    i_rdata   = 32'h0;
    d_ready   = 1'b0;
    d_rdata   = 32'h0;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    timeout   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (i_valid && d_valid) state_d = last_d_q ? BUSY_I : BUSY_D;
        else if (i_valid)       state_d = BUSY_I;
        else if (d_valid)       state_d = BUSY_D;
      end
      BUSY_I: begin
        mem_valid = 1'b1;
        mem_instr = 1'b1;
        mem_addr  = i_addr;
        if (!i_valid) begin
          // The requester withdrew, so the transaction is abandoned without a ready pulse.
          state_d = IDLE;
        end else if (mem_ready) begin
          i_ready  = 1'b1;
          i_rdata  = mem_rdata;
          last_d_d = 1'b0;
          state_d  = IDLE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          i_ready  = 1'b1;
          i_rdata  = 32'hDEADBEEF;
          timeout  = 1'b1;
          last_d_d = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      BUSY_D: begin
        mem_valid = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wstrb = d_wstrb;
        if (!d_valid) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          d_ready  = 1'b1;
          d_rdata  = mem_rdata;
          last_d_d = 1'b1;
          state_d  = IDLE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          d_ready  = 1'b1;
          d_rdata  = 32'hDEADBEEF;
          timeout  = 1'b1;
          last_d_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset is asynchronous and restores the data-served-last state, so fetch wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles a granted transaction waits for mem_ready (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 SHALL have ports: clk  in  1  clock, all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 i_valid  in  1  instruction-fetch request.
REQ-005 i_addr  in  32  fetch address.
REQ-006 i_ready  out  1  fetch complete, i_rdata valid.
REQ-007 i_rdata  out  32  fetched word.
REQ-008 d_valid  in  1  data request.
REQ-009 d_addr / d_wdata  in  32 each  data address / write data.
REQ-010 d_wstrb  in  4  byte strobes, 0000 = read.
REQ-011 d_ready  out  1  data access complete.
REQ-012 d_rdata  out  32  load data.
REQ-013 mem_valid, mem_instr  out  1 each  native-interface request / instruction flag.
REQ-014 mem_addr, mem_wdata  out  32 each; mem_wstrb  out  4.
REQ-015 mem_ready  in  1; mem_rdata  in  32.
REQ-016 timeout  out  1  one-cycle abort pulse.

Function
REQ-017 SHALL be a 3-state FSM: IDLE, BUSY_I (fetch granted), BUSY_D (data granted).
REQ-018 In IDLE, i_valid only -> BUSY_I next cycle; d_valid only -> BUSY_D; neither -> stay IDLE.
REQ-019 In IDLE, both valid -> grant the requester NOT served last (1-bit last_grant register, reset value = data, so fetch wins first tie).
REQ-020 In IDLE, all mem_* outputs SHALL be 0 and i_ready = d_ready = 0.
REQ-021 In BUSY_x, mem_valid = 1, mem_addr/mem_wdata/mem_wstrb pass through combinationally from the granted port; mem_instr = 1 in BUSY_I, 0 in BUSY_D; mem_wdata = 0 and mem_wstrb = 0000 in BUSY_I.
REQ-022 In BUSY_x with mem_ready = 1: granted x_ready = 1 same cycle, x_rdata = mem_rdata; last_grant <- x; FSM -> IDLE next cycle.
REQ-023 Non-granted port's ready SHALL stay 0; i_rdata/d_rdata SHALL be 0 whenever their ready is 0.
REQ-024 Minimum latency request-to-ready = 2 cycles (grant cycle + one BUSY cycle); at least one IDLE cycle between consecutive transactions.
REQ-025 Granted requester dropping valid in BUSY_x before mem_ready (protocol violation) -> FSM -> IDLE next cycle, no ready issued, last_grant unchanged.
REQ-026 mem_ready in IDLE SHALL be ignored.

Reset
REQ-027 reset asserted SHALL immediately force IDLE, last_grant = data, timeout counter = 0, all outputs 0, independent of clk.
REQ-028 Reset mid-transaction SHALL abandon it with no ready pulse; first grant occurs no earlier than the first rising edge after reset deassertion.

Configuration
REQ-029 Macro MEM_ARB_TIMEOUT_EN defined: 8-bit+ counter clears on entering BUSY_x and increments each BUSY cycle without mem_ready; when it equals TIMEOUT_CYCLES, granted x_ready = 1 with x_rdata = 32'hDEADBEEF and timeout = 1 for that cycle, FSM -> IDLE, last_grant <- x.
REQ-030 mem_ready and timeout in the same cycle: mem_ready wins, timeout = 0, normal data returned.
REQ-031 Macro undefined: no counter, timeout tied 0, BUSY_x waits indefinitely for mem_ready.

Verification
REQ-032 i_valid=1, i_addr=0x100, mem_ready pulses with mem_rdata=0x00500093 one cycle after mem_valid -> mem_instr=1, mem_addr=0x100, i_ready=1 with i_rdata=0x00500093 at cycle 2.
REQ-033 i_valid and d_valid rise together out of reset, both held -> fetch served first, then data (d_addr on mem_addr, mem_instr=0), then fetch again: strict alternation.
REQ-034 d_valid=1, d_addr=0x2000, d_wdata=0xCAFEBABE, d_wstrb=1111 -> mem_wstrb=1111, mem_wdata=0xCAFEBABE, d_ready on mem_ready, i_ready stays 0.
REQ-035 reset asserted mid-BUSY_D between clock edges -> mem_valid=0 immediately, no d_ready, fetch granted first after release.
REQ-036 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready held 0 -> d_ready=1, d_rdata=0xDEADBEEF, timeout=1 on 4th BUSY cycle, then IDLE.
